uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmitter, successor to the fixed 8N1 transmitter. It serialises one word per frame with configurable clocks-per-bit, data width, parity mode and stop-bit count. It sits between the control wrapper (valid/ready word source) and the Tx pin. A zero-gap back-to-back path keeps throughput at line rate.

## Interface
- CLKS_PER_BIT, 868: clock cycles per serial bit, ≥2 (868 = 115200 baud @ 100 MHz)
- DATA_BITS, 8: data bits per frame, 5..9
- PARITY, 0: 0 none, 1 odd, 2 even
- STOP_BITS, 1: stop bits, 1 or 2

- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  synchronous reset, active-low
- tx_data  in  DATA_BITS  word to send, sampled on accept
- tx_valid  in  1  tx_data holds a word to send
- tx_ready  out  1  block accepts a word this cycle; accept = tx_valid && tx_ready
- tx_serial  out  1  serial line, idle high
- tx_busy  out  1  high while a frame is on the line (START..STOP)
- tx_done  out  1  one-cycle pulse at end of each frame's final stop bit

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Bit counter is $clog2(CLKS_PER_BIT) wide; bit index is $clog2(DATA_BITS) wide; stop-bit index is 1 bit.
- Reset (rst_n low at posedge): state IDLE, counters 0, shift register 0, tx_serial 1, tx_busy 0, tx_done 0. tx_ready is forced 0 while rst_n is low.
- IDLE: tx_serial 1, tx_ready 1. On accept, latch tx_data into the shift register, compute the parity bit from the latched word, and go to START. tx_valid without accept has no effect.
- START: tx_serial 0 for CLKS_PER_BIT cycles, then DATA.
- DATA: send the word LSB first, each bit for CLKS_PER_BIT cycles. After bit DATA_BITS-1, go to PARITY if PARITY≠0, else STOP.
- PARITY: send one bit for CLKS_PER_BIT cycles, then STOP.
  - Even mode: bit = ^word.
  - Odd mode: bit = ~^word.
- STOP: tx_serial 1 for STOP_BITS×CLKS_PER_BIT cycles.
- At the last cycle of the final stop bit:
  - tx_done is registered high for exactly 1 cycle.
  - tx_ready is 1 in that cycle.
  - If accept occurs in that cycle, latch the new word and go directly to START (zero idle gap). Otherwise go to IDLE.
- tx_ready is 0 in every other non-IDLE cycle. tx_data and tx_valid changes during a frame are ignored.
- PARITY value outside 0..2 is treated as none.

## Timing
- tx_ready is combinational from state, counter and rst_n. tx_serial, tx_busy and tx_done are registered.
- Accept at posedge N: tx_serial goes 0 and tx_busy goes 1 after posedge N, i.e. one-cycle latency.
- Frame length F = CLKS_PER_BIT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- tx_done is high during cycle N+F (counting from the first START cycle, N+1). tx_busy falls after that cycle unless a back-to-back accept occurred.
- Back-to-back: the next start bit begins the cycle immediately after the final stop-bit cycle. Sustained throughput is one word per F cycles.
- Reset mid-frame: the next cycle shows tx_serial=1, tx_busy=0, tx_done=0, state IDLE. The partial frame is abandoned and no tx_done is issued. tx_ready is 1 on the first cycle after rst_n returns high.
- Counter compare uses CLKS_PER_BIT-1. There is no off-by-one: each bit holds exactly CLKS_PER_BIT cycles.

## Test plan
- 8N1, CLKS_PER_BIT=4, send 0xA5:
  - Line = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - tx_done single pulse 40 cycles after the first start cycle; then tx_ready=1, tx_serial=1.
- 8E1, CLKS_PER_BIT=4, send 0x07: parity bit = 1, frame 44 cycles. Same with 8O1: parity bit = 0.
- 7 data bits, PARITY=1, STOP_BITS=2, CLKS_PER_BIT=3, send 0x55:
  - Data 1,0,1,0,1,0,1, parity 1.
  - Two stop bits give 6 high cycles; frame 33 cycles.
- Back-to-back, tx_valid held high with 0x12 then 0x34:
  - Second start bit follows the final stop cycle with no idle cycle.
  - Two tx_done pulses exactly F cycles apart.
  - tx_ready high only in the accept cycles.
- tx_valid pulsed with 0xFF mid-frame while sending 0x00: ignored. Line shows 0x00 data, exactly one tx_done.
- rst_n low for 1 cycle during DATA bit 3:
  - Next cycle tx_serial=1, tx_busy=0.
  - No tx_done.
  - A new 0x3C is accepted on the following cycle and transmits correctly.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
//
// Parametrised UART transmitter. Takes one word per frame from a valid/ready
// source and serialises it onto the Tx line as follows:
//   - start bit (0)
//   - DATA_BITS data bits, LSB first
//   - optional parity bit
//   - STOP_BITS stop bits (1)
// Each bit is held for CLKS_PER_BIT clocks.
//
// Back-to-back: a word offered during the last cycle of the final stop bit
// starts its frame on the very next cycle. This sustains line-rate
// throughput with no idle gap.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   DATA_BITS     data bits per frame (5..9)
//   PARITY        0 none, 1 odd, 2 even (other values behave as none)
//   STOP_BITS     1 or 2
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst_n      synchronous reset, active-low
//   tx_data    word to send, sampled on accept
//   tx_valid   tx_data holds a word to send
//   tx_ready   word accepted this cycle when tx_valid && tx_ready
//   tx_serial  serial line, idle high (registered)
//   tx_busy    high while a frame is on the line (registered)
//   tx_done    one-cycle pulse in the last cycle of the final stop bit
//              (registered)

module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] LAST_CNT   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP  = (STOP_BITS == 2);
    localparam bit            HAS_PARITY = (PARITY == 1) || (PARITY == 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_idx_n;
    logic                 stop_idx, stop_idx_n;
    logic [DATA_BITS-1:0] shift_reg, shift_n;
    logic                 par_bit, par_n;
    logic                 serial_n, busy_n, done_n;

    logic bit_end;
    logic frame_end;
    logic accept;

    // Odd mode inverts the XOR-reduction; even mode uses it directly.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
        return (PARITY == 1) ? ~^word : ^word;
    endfunction

    assign bit_end   = (cnt == LAST_CNT);
    assign frame_end = (state == ST_STOP) && bit_end && (stop_idx == LAST_STOP);

    // Ready in IDLE and in the final stop cycle. The final stop cycle is what
    // lets the next word start without an idle gap.
    assign tx_ready = rst_n && ((state == ST_IDLE) || frame_end);
    assign accept   = tx_valid && tx_ready;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; this is what keeps the block free of inferred latches.
        state_n    = state;
        cnt_n      = cnt;
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        shift_n    = shift_reg;
        par_n      = par_bit;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n    = ST_START;
                    cnt_n      = '0;
                    bit_idx_n  = '0;
                    stop_idx_n = 1'b0;
                    shift_n    = tx_data;
                    par_n      = parity_of(tx_data);
                end
            end

            ST_START: begin
                if (bit_end) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = ST_DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (bit_idx == LAST_BIT) begin
                        state_n    = HAS_PARITY ? ST_PARITY : ST_STOP;
                        stop_idx_n = 1'b0;
                    end else begin
                        bit_idx_n = bit_idx + BW'(1);
                        shift_n   = shift_reg >> 1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            ST_PARITY: begin
                if (bit_end) begin
                    cnt_n      = '0;
                    stop_idx_n = 1'b0;
                    state_n    = ST_STOP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            ST_STOP: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (stop_idx == LAST_STOP) begin
                        if (accept) begin
                            state_n    = ST_START;
                            bit_idx_n  = '0;
                            stop_idx_n = 1'b0;
                            shift_n    = tx_data;
                            par_n      = parity_of(tx_data);
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        stop_idx_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            default: state_n = ST_IDLE;
        endcase

        // The line outputs are registered. They are decoded from the
        // next-cycle state so the line changes with the state, not a cycle
        // after it.
        unique case (state_n)
            ST_START:  serial_n = 1'b0;
            ST_DATA:   serial_n = shift_n[0];
            ST_PARITY: serial_n = par_n;
            default:   serial_n = 1'b1;
        endcase

        busy_n = (state_n != ST_IDLE);
        done_n = (state_n == ST_STOP) && (cnt_n == LAST_CNT) &&
                 (stop_idx_n == LAST_STOP);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            stop_idx  <= stop_idx_n;
            shift_reg <= shift_n;
            par_bit   <= par_n;
            tx_serial <= serial_n;
            tx_busy   <= busy_n;
            tx_done   <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame
//
// Drives four transmitter instances from one shared stimulus source:
//   0: 8N1, 4 clocks/bit
//   1: 8E1, 4 clocks/bit
//   2: 8O1, 4 clocks/bit
//   3: 7 data bits, odd parity, 2 stop bits, 3 clocks/bit
//
// Each single-frame vector names the instance whose line it checks.
// Multi-cycle corner cases run on instance 0:
//   - back-to-back frames
//   - ignored mid-frame valid
//   - reset mid-frame

module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [3:0] rdy, ser, busy, done;

    int n_checks = 0;
    int n_pass   = 0;

    logic cap_ser  [0:127];
    logic cap_done [0:127];
    logic cap_rdy  [0:127];
    logic cap_busy [0:127];

    always #5 clk = ~clk;

    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy[0]), .tx_serial(ser[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy[1]), .tx_serial(ser[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy[2]), .tx_serial(ser[2]), .tx_busy(busy[2]), .tx_done(done[2]));
    uart_tx_frame #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[6:0]), .tx_valid(tx_valid),
        .tx_ready(rdy[3]), .tx_serial(ser[3]), .tx_busy(busy[3]), .tx_done(done[3]));

    typedef struct {
        int         cfg;
        int         cpb;
        logic [7:0] word;
        string      line;   // expected level of each frame bit, start bit first
        int         flen;
    } vec_t;

    vec_t vecs[5];

    function automatic vec_t mk(input int cfg, input int cpb, input logic [7:0] word,
                                input string line);
        vec_t v;
        v.cfg  = cfg;
        v.cpb  = cpb;
        v.word = word;
        v.line = line;
        v.flen = cpb * line.len();
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else
            n_pass++;
    endtask

    // Record instance c's outputs for cycle k (sampled mid-cycle).
    task automatic sample(input int k, input int c);
        @(negedge clk);
        cap_ser[k]  = ser[c];
        cap_done[k] = done[c];
        cap_rdy[k]  = rdy[c];
        cap_busy[k] = busy[c];
    endtask

    // Read the data bits of a frame starting at cycle 'start' by sampling
    // the middle of each data bit.
    function automatic logic [7:0] decode(input int start, input int cpb, input int nb);
        logic [7:0] r = '0;
        for (int j = 0; j < nb; j++)
            r[j] = cap_ser[start + cpb * (1 + j) + cpb / 2];
        return r;
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy == 4'h0) break;
        end
        check("idle wait", {28'd0, busy}, 32'd0);
    endtask

    // Offer one word for a single accept edge; returns just after that edge.
    task automatic send(input logic [7:0] w);
        @(negedge clk);
        tx_data  = w;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic run_vector(input int vi);
        vec_t v = vecs[vi];
        int   bad, nd, nb, nr;
        wait_idle();
        send(v.word);
        for (int k = 1; k <= v.flen + 1; k++) sample(k, v.cfg);
        for (int b = 0; b < v.line.len(); b++) begin
            logic e = (v.line[b] == "1");
            bad = 0;
            for (int c = 0; c < v.cpb; c++)
                if (cap_ser[1 + b * v.cpb + c] !== e) bad++;
            check($sformatf("v%0d bit%0d wrong cycles", vi, b), bad, 0);
        end
        nd = 0; nb = 0; nr = 0;
        for (int k = 1; k <= v.flen + 1; k++) nd += int'(cap_done[k]);
        for (int k = 1; k <= v.flen; k++) nb += int'(cap_busy[k]);
        for (int k = 1; k < v.flen; k++) nr += int'(cap_rdy[k]);
        check($sformatf("v%0d done count", vi), nd, 1);
        check($sformatf("v%0d done at F", vi), cap_done[v.flen], 1);
        check($sformatf("v%0d busy cycles", vi), nb, v.flen);
        check($sformatf("v%0d ready mid-frame", vi), nr, 0);
        check($sformatf("v%0d ready final stop", vi), cap_rdy[v.flen], 1);
        check($sformatf("v%0d after frame rdy/ser/busy", vi),
              {cap_rdy[v.flen + 1], cap_ser[v.flen + 1], cap_busy[v.flen + 1]}, 3'b110);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd, nr, d1, d2;

        vecs[0] = mk(0, 4, 8'hA5, "0101001011");
        vecs[1] = mk(1, 4, 8'h07, "01110000011");
        vecs[2] = mk(2, 4, 8'h07, "01110000001");
        vecs[3] = mk(3, 3, 8'h55, "01010101111");
        vecs[4] = mk(0, 4, 8'h3C, "0001111001");

        // Reset state.
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset serial", ser, 4'hF);
        check("reset busy", busy, 4'h0);
        check("reset done", done, 4'h0);
        check("reset ready", rdy, 4'h0);
        rst_n = 1'b1;
        #1 check("ready after reset", rdy, 4'hF);

        for (int vi = 0; vi < 5; vi++) run_vector(vi);

        // Back-to-back on instance 0, F = 40, valid held high.
        wait_idle();
        @(negedge clk);
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_data = 8'h34;
        for (int k = 1; k <= 81; k++) begin
            sample(k, 0);
            if (k == 41) tx_valid = 1'b0;
        end
        check("b2b word1", decode(1, 4, 8), 8'h12);
        check("b2b word2", decode(41, 4, 8), 8'h34);
        check("b2b stop then start", {cap_ser[40], cap_ser[41]}, 2'b10);
        check("b2b busy no gap", cap_busy[41], 1);
        nd = 0; nr = 0; d1 = 0; d2 = 0;
        for (int k = 1; k <= 81; k++) begin
            if (cap_done[k]) begin
                nd++;
                if (d1 == 0) d1 = k; else d2 = k;
            end
        end
        for (int k = 1; k < 80; k++) nr += int'(cap_rdy[k]);
        check("b2b done count", nd, 2);
        check("b2b first done", d1, 40);
        check("b2b done spacing", d2 - d1, 40);
        check("b2b ready cycles", nr, 1);
        check("b2b ready at accept", cap_rdy[40], 1);

        // tx_valid pulsed with 0xFF mid-frame while 0x00 is on the line.
        wait_idle();
        send(8'h00);
        for (int k = 1; k <= 44; k++) begin
            sample(k, 0);
            if (k == 10) begin
                tx_data  = 8'hFF;
                tx_valid = 1'b1;
            end else if (k == 11) begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
        end
        nd = 0; nr = 0;
        for (int k = 1; k <= 44; k++) nd += int'(cap_done[k]);
        for (int k = 41; k <= 44; k++) nr += int'(cap_busy[k]);
        check("midvalid data", decode(1, 4, 8), 8'h00);
        check("midvalid done count", nd, 1);
        check("midvalid done at F", cap_done[40], 1);
        check("midvalid no new frame", nr, 0);

        // One-cycle reset during data bit 3 (cycles 17..20), then send 0x3C.
        wait_idle();
        send(8'hA5);
        for (int k = 1; k <= 19; k++) begin
            sample(k, 0);
            if (k == 18) rst_n = 1'b0;
        end
        nd = 0;
        for (int k = 1; k <= 19; k++) nd += int'(cap_done[k]);
        check("rst no done", nd, 0);
        check("rst serial/busy/done", {cap_ser[19], cap_busy[19], cap_done[19]}, 3'b100);
        check("rst ready low", cap_rdy[19], 0);
        check("rst all idle", busy, 4'h0);
        rst_n = 1'b1;
        #1 check("rst ready after release", rdy[0], 1);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        for (int k = 1; k <= 41; k++) sample(k, 0);
        nd = 0;
        for (int k = 1; k <= 41; k++) nd += int'(cap_done[k]);
        check("post-rst start bit", cap_ser[2], 0);
        check("post-rst data", decode(1, 4, 8), 8'h3C);
        check("post-rst done count", nd, 1);
        check("post-rst done at F", cap_done[40], 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
